// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with one outstanding memory request, stall hold and redirect squashing.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} state_e;
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, target;
    logic        valid_q, valid_d;
    assign target   = {PCTargetE[31:2], 2'b00};
    assign PCF      = pc_q;
    assign PCPlus4F = pc_q + 32'd4;
    assign InstrF   = instr_q;
    assign ValidF   = valid_q;
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            IDLE: begin
                imem_req  = 1'b1;
                pc_d      = PCSrcE ? target : pc_q;
                imem_addr = pc_d;
                state_d   = WAIT;
            end
            WAIT: begin
                if (PCSrcE) begin
                    pc_d    = target;
                    state_d = imem_rvalid ? IDLE : DISCARD;
                end else if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // a redirect overrides a stall
                if (PCSrcE || !Stall) begin
                    imem_req  = 1'b1;
                    pc_d      = PCSrcE ? target : PCPlus4F;
                    imem_addr = pc_d;
                    valid_d   = 1'b0;
                    instr_d   = NOP;
                    state_d   = WAIT;
                end
            end
            DISCARD: begin
                pc_d    = PCSrcE ? target : pc_q;
                state_d = imem_rvalid ? IDLE : DISCARD;
            end
            default: state_d = IDLE;
        endcase
        if (rst) imem_req = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit; inputs driven on negedge, outputs checked 1ns later.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst, Stall, PCSrcE, imem_rvalid;
    logic [31:0] PCTargetE, imem_rdata;
    logic        imem_req, ValidF;
    logic [31:0] imem_addr, InstrF, PCF, PCPlus4F;
    int errs = 0;
    int checks = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .Stall(Stall), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .ValidF(ValidF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resp_adv(input logic [31:0] data);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; Stall = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        step(); step();
        #1;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_pcf", PCF, 32'h0);
        check("rst_valid", {31'b0, ValidF}, 32'd0);
        check("rst_instr", InstrF, NOP);
        rst = 1'b0; #1;
        check("idle_req", {31'b0, imem_req}, 32'd1);
        check("idle_addr", imem_addr, 32'h0);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; #1;
        check("wait_req", {31'b0, imem_req}, 32'd0);
        step();
        imem_rvalid = 1'b0; Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_valid", {31'b0, ValidF}, 32'd1);
            check("hold_instr", InstrF, 32'h0050_0093);
            check("hold_pcf", PCF, 32'h0);
            check("hold_pc4", PCPlus4F, 32'h4);
            check("stall_req", {31'b0, imem_req}, 32'd0);
            step();
        end
        Stall = 1'b0; #1;
        check("adv_req", {31'b0, imem_req}, 32'd1);
        check("adv_addr", imem_addr, 32'h4);
        step(); #1;
        check("adv_pcf", PCF, 32'h4);
        check("adv_valid", {31'b0, ValidF}, 32'd0);
        check("adv_instr", InstrF, NOP);
        resp_adv(32'h11); resp_adv(32'h22); resp_adv(32'h33);
        #1 check("pc10", PCF, 32'h10);
        PCSrcE = 1'b1; PCTargetE = 32'h80;
        step();
        PCSrcE = 1'b0; #1;
        check("disc_req", {31'b0, imem_req}, 32'd0);
        check("disc_valid", {31'b0, ValidF}, 32'd0);
        check("disc_pcf", PCF, 32'h80);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD; #1;
        check("disc_req2", {31'b0, imem_req}, 32'd0);
        step();
        imem_rvalid = 1'b0; #1;
        check("drop_valid", {31'b0, ValidF}, 32'd0);
        check("drop_instr", InstrF, NOP);
        check("redir_req", {31'b0, imem_req}, 32'd1);
        check("redir_addr", imem_addr, 32'h80);
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h40; imem_rvalid = 1'b1; imem_rdata = 32'hBAD; #1;
        check("both_req", {31'b0, imem_req}, 32'd0);
        step();
        PCSrcE = 1'b0; imem_rvalid = 1'b0; #1;
        check("both_valid", {31'b0, ValidF}, 32'd0);
        check("both_pcf", PCF, 32'h40);
        check("both_req2", {31'b0, imem_req}, 32'd1);
        check("both_addr", imem_addr, 32'h40);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h33;
        step();
        imem_rvalid = 1'b0; Stall = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h203; #1;
        check("prio_req", {31'b0, imem_req}, 32'd1);
        check("prio_addr", imem_addr, 32'h200);
        step();
        PCSrcE = 1'b0; Stall = 1'b0; #1;
        check("prio_pcf", PCF, 32'h200);
        check("prio_valid", {31'b0, ValidF}, 32'd0);
        check("prio_wait_req", {31'b0, imem_req}, 32'd0);
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; imem_rvalid = 1'b1;
        step();
        PCSrcE = 1'b0; imem_rvalid = 1'b0; #1;
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h44;
        step();
        imem_rvalid = 1'b0; Stall = 1'b1; #1;
        check("top_pcf", PCF, 32'hFFFF_FFFC);
        check("wrap_pc4", PCPlus4F, 32'h0);
        check("top_instr", InstrF, 32'h44);
        Stall = 1'b0; #1;
        check("wrap_req", {31'b0, imem_req}, 32'd1);
        check("wrap_addr", imem_addr, 32'h0);
        step();
        rst = 1'b1; #1;
        check("rst_mid_req", {31'b0, imem_req}, 32'd0);
        step();
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h55; #1;
        check("late_req", {31'b0, imem_req}, 32'd1);
        check("late_addr", imem_addr, 32'h0);
        step();
        imem_rvalid = 1'b0; #1;
        check("late_valid", {31'b0, ValidF}, 32'd0);
        check("late_wait_req", {31'b0, imem_req}, 32'd0);
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        step();
        PCTargetE = 32'h300;
        step();
        PCSrcE = 1'b0; #1;
        check("disc2_pcf", PCF, 32'h300);
        check("disc2_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        step();
        imem_rvalid = 1'b0; #1;
        check("disc2_addr", imem_addr, 32'h300);
        check("disc2_idle_req", {31'b0, imem_req}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
